alu_sequencer: RTL
==================

# alu_sequencer

- Owns the ALU's operand and command inputs.
- Accepts operation requests over a valid/ready handshake and drives the registered `command`/`operandA`/`operandB` onto the 32-bit ripple ALU.
- Waits a programmable settle time for the gate-delayed carry chain, captures `result` and flags, and returns them over a valid/ready response channel.
- Also implements an unsigned 32×32→32 multiply as a shift-and-add loop of ALU ADDs; it sits between the datapath control and the ALU.

## Interface
- `SETTLE_CYCLES`, 4: clock cycles the ALU inputs are held stable before its outputs are sampled; legal range 1..15.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: sequencer can accept a request.
- `req_cmd` input 4: bit 3 = 0 selects ALU op `req_cmd[2:0]`; `4'b1000` = MUL; other values with bit 3 set are illegal.
- `req_a`, `req_b` input 32 each: operands.
- `alu_command` output 3: to ALU `command`.
- `alu_operandA`, `alu_operandB` output 32 each: to ALU operands.
- `alu_result` input 32, `alu_carryout`/`alu_zero`/`alu_overflow` input 1 each: from ALU.
- `rsp_valid` output 1, `rsp_ready` input 1: response handshake.
- `rsp_result` output 32; `rsp_carry`, `rsp_zero`, `rsp_overflow`, `rsp_err` output 1 each.

## Operation
- **States:** IDLE, SETTLE, MUL_CHK, MUL_ADD, RESP.
- **IDLE**
  - `req_ready`=1. On `req_valid`, latch cmd/a/b.
  - ALU op: drive `alu_command`=cmd[2:0], operands=a/b; cnt←SETTLE_CYCLES−1; go to SETTLE.
  - MUL: acc←0, mcand←a, mplier←b, iter←0, sticky←0; go to MUL_CHK.
  - Illegal cmd: `rsp_result`=0, flags=0, `rsp_err`=1; go to RESP.
- **SETTLE**
  - cnt≠0: cnt−1.
  - cnt=0: register `alu_result`, `alu_carryout`, `alu_zero`, `alu_overflow` into the `rsp_*` outputs, `rsp_err`=0; go to RESP.
  - The response passes the ALU's own flags through unmodified.
- **MUL_CHK** (one cycle per iteration)
  - If mplier=0 or iter=32: `rsp_result`=acc, `rsp_carry`=0, `rsp_overflow`=sticky, `rsp_zero`=(acc==0), `rsp_err`=0; go to RESP.
  - Else if mplier[0]=1: drive ADD(acc, mcand); cnt←SETTLE_CYCLES−1; go to MUL_ADD.
  - Else shift, with the same shift step as MUL_ADD.
- **Shift step:** mcand←mcand<<1, mplier←mplier>>1, iter+1, and sticky|=mcand[31]&(mplier>>1 ≠ 0).
- **MUL_ADD**
  - Same countdown as SETTLE.
  - At cnt=0: acc←`alu_result`, sticky|=`alu_carryout`, apply the shift step, return to MUL_CHK.
- **MUL overflow semantics:** sticky is set exactly when the 64-bit unsigned product exceeds 32 bits. Result is the low 32 bits.
- **RESP:** `rsp_valid`=1; outputs held stable until `rsp_ready`=1 at a rising edge, then go to IDLE. `req_ready`=0 in every state except IDLE, so there is one op in flight with no overlap.
- **ALU drive:** `alu_*` outputs come directly from registers and change only on entry to SETTLE/MUL_ADD. They hold their last value otherwise.

## Timing
- **Reset (async assert, sync deassert by `clk`):**
  - State=IDLE.
  - `req_ready`=0 while `rst_n`=0, 1 from the first edge after release.
  - `rsp_valid`=0; all `rsp_*`=0.
  - `alu_command`=3'b000 (ADD); `alu_operandA`/`alu_operandB`=0; internal counters 0.
- **ALU-op latency:** accept at edge E0 → result captured at edge E0+SETTLE_CYCLES → `rsp_valid` high in that cycle.
  - Back-to-back throughput: one op per SETTLE_CYCLES+2 cycles when `rsp_ready` is held 1.
- **MUL latency:** 1 cycle per zero multiplier bit, SETTLE_CYCLES+1 per one bit, plus 1 final check.
  - Early exit when mplier=0, so b=0 gives `rsp_valid` 1 cycle after accept.
- **Reset mid-operation** aborts immediately to the reset values; no response is emitted.
- **Request while busy:** `req_valid` with `req_ready`=0 is ignored. The requester must hold it.
- **Response stall:** `rsp_ready` low holds RESP indefinitely, with outputs unchanged.

## Structure
- **Shared package:** opcode constants ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7, MUL=4'b1000, and the state encoding. These are the same opcode definitions the ALU control decoder uses.
- **Sub-module:** `settle_counter` (load, decrement, done=cnt==0). It is instantiated once and shared by SETTLE and MUL_ADD.
- The bench instantiates the real ALU connected to the `alu_*` ports.

## Test plan
- ADD a=0x7FFFFFFF, b=1, SETTLE_CYCLES=4 → `rsp_valid` 4 cycles after accept, result 0x80000000, overflow=1, carry=0.
- SUB a=5, b=5 → result 0, carry=1, zero as reported by the ALU; `alu_*` stable for all 4 settle cycles.
- MUL a=0x0000FFFF, b=0x00010001 → result 0xFFFFFFFF, overflow=0. MUL a=0x10000, b=0x10000 → result 0, overflow=1, zero=1.
- MUL b=0 → `rsp_valid` 1 cycle after accept, result 0. Illegal cmd 4'b1011 → `rsp_err`=1, result 0.
- Hold `rsp_ready`=0 for 10 cycles with a new `req_valid` pending → response stable, `req_ready`=0. Release → request accepted the cycle after IDLE is entered.
- Assert `rst_n`=0 mid-MUL → outputs return to reset values within the same cycle; no `rsp_valid`; next ADD completes correctly.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode constants and sequencer state encoding for the ALU sequencer.
// The ALU opcodes match the ones used by the ALU control decoder.
package alu_sequencer_pkg;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_NOR  = 3'd6;
  localparam logic [2:0] ALU_OR   = 3'd7;
  localparam logic [3:0] CMD_MUL  = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MUL_CHK = 3'd2,
    S_MUL_ADD = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] cmd);
    return ~cmd[3];
  endfunction

endpackage

// File: rtl/alu_sequencer_settle_counter.sv
// Loadable down-counter that times how long the ALU inputs are held
// before its gate-delayed outputs are sampled.
module settle_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences single ALU operations and shift-and-add multiplies onto a ripple ALU,
// waiting a programmable settle time before sampling its outputs.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [2:0]  alu_command,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic        rsp_err
);

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

  state_t      r_state, w_next_state;
  logic        r_req_ready, r_rsp_valid;
  logic [2:0]  r_alu_command;
  logic [31:0] r_alu_operandA, r_alu_operandB;
  logic [31:0] r_acc, r_mcand, r_mplier;
  logic [5:0]  r_iter;
  logic        r_sticky;
  logic [31:0] r_rsp_result;
  logic        r_rsp_carry, r_rsp_zero, r_rsp_overflow, r_rsp_err;

  logic        w_cnt_load, w_cnt_dec, w_cnt_done;
  logic        w_drive;
  logic [2:0]  w_drv_cmd;
  logic [31:0] w_drv_a, w_drv_b;
  logic        w_mul_init, w_shift, w_acc_cap;
  logic        w_cap_alu, w_cap_mul, w_cap_err;

  settle_counter #(.W(4)) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_cnt_dec),
    .o_done     (w_cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_req_ready <= (w_next_state == S_IDLE);
      r_rsp_valid <= (w_next_state == S_RESP);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;
    w_drive      = 1'b0;
    w_drv_cmd    = r_alu_command;
    w_drv_a      = r_alu_operandA;
    w_drv_b      = r_alu_operandB;
    w_mul_init   = 1'b0;
    w_shift      = 1'b0;
    w_acc_cap    = 1'b0;
    w_cap_alu    = 1'b0;
    w_cap_mul    = 1'b0;
    w_cap_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_req_ready && req_valid) begin
          if (is_alu_op(req_cmd)) begin
            w_drive      = 1'b1;
            w_drv_cmd    = req_cmd[2:0];
            w_drv_a      = req_a;
            w_drv_b      = req_b;
            w_cnt_load   = 1'b1;
            w_next_state = S_SETTLE;
          end else if (req_cmd == CMD_MUL) begin
            w_mul_init   = 1'b1;
            w_next_state = S_MUL_CHK;
          end else begin
            w_cap_err    = 1'b1;
            w_next_state = S_RESP;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (w_cnt_done) begin
          w_cap_alu    = 1'b1;
          w_next_state = S_RESP;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      S_MUL_CHK: begin
        if ((r_mplier == 32'd0) || (r_iter == 6'd32)) begin
          w_cap_mul    = 1'b1;
          w_next_state = S_RESP;
        end else if (r_mplier[0]) begin
          w_drive      = 1'b1;
          w_drv_cmd    = ALU_ADD;
          w_drv_a      = r_acc;
          w_drv_b      = r_mcand;
          w_cnt_load   = 1'b1;
          w_next_state = S_MUL_ADD;
        end else begin
          w_shift = 1'b1;
        end
      end
      S_MUL_ADD: begin
        if (w_cnt_done) begin
          w_acc_cap    = 1'b1;
          w_shift      = 1'b1;
          w_next_state = S_MUL_CHK;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RESP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Multiply datapath; sticky records any product bit lost above bit 31.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= 32'd0;
      r_mcand  <= 32'd0;
      r_mplier <= 32'd0;
      r_iter   <= 6'd0;
      r_sticky <= 1'b0;
    end else if (w_mul_init) begin
      r_acc    <= 32'd0;
      r_mcand  <= req_a;
      r_mplier <= req_b;
      r_iter   <= 6'd0;
      r_sticky <= 1'b0;
    end else begin
      if (w_acc_cap) begin
        r_acc <= alu_result;
      end
      if (w_shift) begin
        r_mcand  <= {r_mcand[30:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[31:1]};
        r_iter   <= r_iter + 6'd1;
        r_sticky <= r_sticky | (w_acc_cap & alu_carryout) | (r_mcand[31] & (|r_mplier[31:1]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_command  <= ALU_ADD;
      r_alu_operandA <= 32'd0;
      r_alu_operandB <= 32'd0;
    end else if (w_drive) begin
      r_alu_command  <= w_drv_cmd;
      r_alu_operandA <= w_drv_a;
      r_alu_operandB <= w_drv_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result   <= 32'd0;
      r_rsp_carry    <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_err      <= 1'b0;
    end else if (w_cap_alu) begin
      r_rsp_result   <= alu_result;
      r_rsp_carry    <= alu_carryout;
      r_rsp_zero     <= alu_zero;
      r_rsp_overflow <= alu_overflow;
      r_rsp_err      <= 1'b0;
    end else if (w_cap_mul) begin
      r_rsp_result   <= r_acc;
      r_rsp_carry    <= 1'b0;
      r_rsp_zero     <= (r_acc == 32'd0);
      r_rsp_overflow <= r_sticky;
      r_rsp_err      <= 1'b0;
    end else if (w_cap_err) begin
      r_rsp_result   <= 32'd0;
      r_rsp_carry    <= 1'b0;
      r_rsp_zero     <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_err      <= 1'b1;
    end
  end

  assign req_ready    = r_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign alu_command  = r_alu_command;
  assign alu_operandA = r_alu_operandA;
  assign alu_operandB = r_alu_operandB;
  assign rsp_result   = r_rsp_result;
  assign rsp_carry    = r_rsp_carry;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_err      = r_rsp_err;

endmodule
